// File: rtl/dram_pkg.sv
// Shared DRAM timing constants (in controller clock cycles) and the counter
// width used by every delay counter and the refresh interval timer.
package dram_pkg;

    localparam int unsigned CNT_W = 16;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam int unsigned tRCD  = 14;
    localparam int unsigned tWR   = 16;
    localparam int unsigned CL    = 18;
    localparam int unsigned CWL   = 10;
    localparam int unsigned BL    = 8;
    localparam int unsigned tRP   = 14;
    localparam int unsigned tRFC  = 280;
    localparam int unsigned tREFI = 6240;

    // Composite delays seen by the command FSM from issue to completion.
    localparam int unsigned T_WR_TOT_DEF = CWL + BL / 2 + tWR;
    localparam int unsigned T_RD_TOT_DEF = CL + BL / 2;

    localparam int unsigned MAX_POSTPONE_DEF = 8;

endpackage

// File: rtl/timing_signals_if.sv
// Completion strobes and refresh request passed from the timing controller
// to the wait states of the DRAM command FSM.
interface timing_signals_if;

    logic tACT_done;
    logic tWR_done;
    logic tRD_done;
    logic tPRE_done;
    logic tREF_done;
    logic rf_req;

    modport timing_ctrl (
        output tACT_done, tWR_done, tRD_done, tPRE_done, tREF_done, rf_req
    );

    modport cmd_fsm (
        input tACT_done, tWR_done, tRD_done, tPRE_done, tREF_done, rf_req
    );

endinterface

// File: rtl/dram_timing_counter.sv
// Loadable down-counter that emits a one-cycle registered pulse T cycles
// after the load strobe; a reload while counting restarts the delay.
module dram_timing_counter
    import dram_pkg::*;
#(
    parameter int unsigned T = 1
)(
    input  logic CLK,
    input  logic RST,
    input  logic load,
    output logic done_pulse
);

    cnt_t count;

    // The count holds cycles still to wait after the load edge, so it is
    // loaded with T-1 and the pulse lands exactly T cycles after issue.
    always_ff @(posedge CLK) begin
        if (RST) begin
            count      <= '0;
            done_pulse <= 1'b0;
        end else if (load) begin
            count      <= cnt_t'(T - 1);
            done_pulse <= (T == 1);
        end else if (count != '0) begin
            count      <= count - cnt_t'(1);
            done_pulse <= (count == cnt_t'(1));
        end else begin
            done_pulse <= 1'b0;
        end
    end

endmodule

// File: rtl/dram_timing_ctrl.sv
// Per-command delay channels plus the tREFI timer that tracks postponed
// refreshes and raises rf_req for the command FSM.
module dram_timing_ctrl
    import dram_pkg::*;
#(
    parameter int unsigned T_RCD        = tRCD,
    parameter int unsigned T_WR_TOT     = T_WR_TOT_DEF,
    parameter int unsigned T_RD_TOT     = T_RD_TOT_DEF,
    parameter int unsigned T_RP         = tRP,
    parameter int unsigned T_RFC        = tRFC,
    parameter int unsigned T_REFI       = tREFI,
    parameter int unsigned MAX_POSTPONE = MAX_POSTPONE_DEF
)(
    input  logic                                CLK,
    input  logic                                RST,
    input  logic                                refresh_en,
    input  logic                                issue_act,
    input  logic                                issue_wr,
    input  logic                                issue_rd,
    input  logic                                issue_pre,
    input  logic                                issue_ref,
    timing_signals_if.timing_ctrl               tif,
    output logic [$clog2(MAX_POSTPONE+1)-1:0]   ref_pending,
    output logic                                ref_overflow
);

    localparam int unsigned PW = $clog2(MAX_POSTPONE + 1);

    dram_timing_counter #(.T(T_RCD))    actCounter (.CLK(CLK), .RST(RST), .load(issue_act), .done_pulse(tif.tACT_done));
    dram_timing_counter #(.T(T_WR_TOT)) wrCounter  (.CLK(CLK), .RST(RST), .load(issue_wr),  .done_pulse(tif.tWR_done));
    dram_timing_counter #(.T(T_RD_TOT)) rdCounter  (.CLK(CLK), .RST(RST), .load(issue_rd),  .done_pulse(tif.tRD_done));
    dram_timing_counter #(.T(T_RP))     preCounter (.CLK(CLK), .RST(RST), .load(issue_pre), .done_pulse(tif.tPRE_done));
    dram_timing_counter #(.T(T_RFC))    refCounter (.CLK(CLK), .RST(RST), .load(issue_ref), .done_pulse(tif.tREF_done));

    cnt_t          refiCount;
    logic          expiry;
    logic [PW-1:0] pendingNext;
    logic          overflowNext;

    assign expiry = refresh_en && (refiCount == cnt_t'(1));

    // Free-running interval: a REF does not restart it, so the average
    // refresh rate stays fixed regardless of when refreshes are issued.
    always_ff @(posedge CLK) begin
        if (RST) begin
            refiCount <= cnt_t'(T_REFI);
        end else if (refresh_en) begin
            refiCount <= expiry ? cnt_t'(T_REFI) : refiCount - cnt_t'(1);
        end
    end

    always_comb begin
        pendingNext  = ref_pending;
        overflowNext = ref_overflow;
        if (expiry && !issue_ref) begin
            if (ref_pending == PW'(MAX_POSTPONE)) begin
                overflowNext = 1'b1;
            end else begin
                pendingNext = ref_pending + PW'(1);
            end
        end else if (!expiry && issue_ref && (ref_pending != '0)) begin
            pendingNext = ref_pending - PW'(1);
        end
    end

    // rf_req is derived from the next pending value so it moves in the
    // same cycle as ref_pending.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ref_pending  <= '0;
            ref_overflow <= 1'b0;
            tif.rf_req   <= 1'b0;
        end else begin
            ref_pending  <= pendingNext;
            ref_overflow <= overflowNext;
            tif.rf_req   <= (pendingNext != '0);
        end
    end

endmodule

// File: tb/tb_dram_timing_ctrl.sv
// Directed bench for dram_timing_ctrl with short timing values so every
// delay, overflow and freeze case fits in a few hundred cycles.
module tb_dram_timing_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       refresh_en = 1'b0;
    logic       issue_act = 1'b0;
    logic       issue_wr = 1'b0;
    logic       issue_rd = 1'b0;
    logic       issue_pre = 1'b0;
    logic       issue_ref = 1'b0;
    logic [3:0] ref_pending;
    logic       ref_overflow;

    int checks = 0;
    int errors = 0;

    timing_signals_if tif();

    dram_timing_ctrl #(
        .T_RCD(4), .T_WR_TOT(6), .T_RD_TOT(5), .T_RP(3),
        .T_RFC(8), .T_REFI(10), .MAX_POSTPONE(8)
    ) dut (
        .CLK(CLK), .RST(RST), .refresh_en(refresh_en),
        .issue_act(issue_act), .issue_wr(issue_wr), .issue_rd(issue_rd),
        .issue_pre(issue_pre), .issue_ref(issue_ref),
        .tif(tif), .ref_pending(ref_pending), .ref_overflow(ref_overflow)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Advance to 1 time unit after the next rising edge; strobes last one cycle.
    task automatic applyStimulus();
        @(posedge CLK);
        #1;
        issue_act = 1'b0;
        issue_wr  = 1'b0;
        issue_rd  = 1'b0;
        issue_pre = 1'b0;
        issue_ref = 1'b0;
    endtask

    task automatic resetDut();
        RST = 1'b1;
        refresh_en = 1'b0;
        applyStimulus();
        applyStimulus();
        RST = 1'b0;
    endtask

    function automatic int doneBus();
        return {tif.tACT_done, tif.tWR_done, tif.tRD_done, tif.tPRE_done, tif.tREF_done};
    endfunction

    initial begin
        // Reset state and ACT delay of 4 cycles
        resetDut();
        checkOutput("reset dones", doneBus(), 0);
        checkOutput("reset rf_req", tif.rf_req, 0);
        checkOutput("reset pending", ref_pending, 0);
        checkOutput("reset overflow", ref_overflow, 0);
        for (int c = 0; c <= 7; c++) begin
            if (c == 0) issue_act = 1'b1;
            checkOutput($sformatf("act c%0d", c), doneBus(), (c == 4) ? 5'b10000 : 0);
            applyStimulus();
        end

        // PRE re-issued on its expiry cycle drops the first pulse
        resetDut();
        for (int c = 0; c <= 8; c++) begin
            if (c == 0 || c == 2) issue_pre = 1'b1;
            checkOutput($sformatf("pre c%0d", c), tif.tPRE_done, (c == 5) ? 1 : 0);
            applyStimulus();
        end

        // Reset in the middle of an RD count suppresses its pulse
        resetDut();
        for (int c = 0; c <= 10; c++) begin
            if (c == 0) issue_rd = 1'b1;
            RST = (c == 3);
            checkOutput($sformatf("rdrst c%0d", c), tif.tRD_done, 0);
            if (c >= 4)
                checkOutput($sformatf("rdrst all c%0d", c),
                            {doneBus(), 32'(tif.rf_req), 32'(ref_pending), 32'(ref_overflow)}, 0);
            applyStimulus();
        end
        RST = 1'b0;

        // Simultaneous strobes on four channels; REF at zero pending is ignored
        resetDut();
        for (int c = 0; c <= 9; c++) begin
            if (c == 0) begin
                issue_act = 1'b1;
                issue_wr  = 1'b1;
                issue_rd  = 1'b1;
                issue_ref = 1'b1;
            end
            checkOutput($sformatf("multi c%0d", c), doneBus(),
                        (c == 4) ? 5'b10000 : (c == 5) ? 5'b00100 :
                        (c == 6) ? 5'b01000 : (c == 8) ? 5'b00001 : 0);
            checkOutput($sformatf("multi pend c%0d", c), ref_pending, 0);
            applyStimulus();
        end

        // Refresh request, REF service, REF on expiry cycle, then freeze
        resetDut();
        refresh_en = 1'b1;
        for (int c = 0; c <= 95; c++) begin
            automatic int expPend;
            if (c == 12 || c == 29) issue_ref = 1'b1;
            refresh_en = !(c >= 36 && c < 86);
            if (c < 10)       expPend = 0;
            else if (c <= 12) expPend = 1;
            else if (c < 20)  expPend = 0;
            else if (c < 90)  expPend = 1;
            else              expPend = 2;
            checkOutput($sformatf("refi pend c%0d", c), ref_pending, expPend);
            checkOutput($sformatf("refi req c%0d", c), tif.rf_req, (expPend != 0) ? 1 : 0);
            applyStimulus();
        end

        // Postponed refreshes saturate at 8 and the overflow flag sticks
        resetDut();
        refresh_en = 1'b1;
        for (int c = 0; c <= 100; c++) begin
            checkOutput($sformatf("sat pend c%0d", c), ref_pending, (c / 10 > 8) ? 8 : c / 10);
            checkOutput($sformatf("sat ovf c%0d", c), ref_overflow, (c >= 90) ? 1 : 0);
            checkOutput($sformatf("sat req c%0d", c), tif.rf_req, (c >= 10) ? 1 : 0);
            applyStimulus();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
